// File: rtl/barrier_types.sv
// Shared barrier types.
// Holds the per-warp barrier state encoding, the per-warp stored barrier fields,
// and the field widths used on the BAR / arrive / release channels.
package barrier_types;

    localparam int WARP_ID_W     = 6;
    localparam int BAR_ID_W      = 16;
    localparam int BLOCK_ID_W    = 10;
    localparam int THREAD_MASK_W = 32;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        PENDING = 2'd1,
        SENDING = 2'd2,
        WAITING = 2'd3
    } warp_bar_state_e;

    typedef struct packed {
        logic [BAR_ID_W-1:0]      barrier_id;
        logic [BLOCK_ID_W-1:0]    block_id;
        logic [THREAD_MASK_W-1:0] thread_mask;
    } warp_bar_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick plus a registered start pointer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         request vector
//   advance     the current grant was taken; move priority past it
//   grant       one-hot grant (zero when no request)
//   valid       some request is granted
module rr_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // ptr_q is the highest-priority index; it moves to one past each taken grant.
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && valid) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/barrier_arrival_unit.sv
// Warp-side barrier initiator.
// Accepts BAR instructions from issue, stalls the issuing warp, serializes the
// arrivals onto the controller's arrive valid/ready channel in round-robin order,
// and resumes warps named by matching release messages.
// Ports:
//   bar_*            BAR instruction from issue (always sampled), bar_error pulse on drop
//   arrive_*         registered arrive request to the barrier controller
//   release_*        release message from the controller (release_ready = out of reset)
//   warp_stalled     per-warp "not RUNNING"
//   warp_resume      one-cycle pulse per released warp
//   arrive_count, stalled_warp_cycles, spurious_release_count  statistics
module barrier_arrival_unit
    import barrier_types::*;
#(
    parameter int NUM_WARPS       = 32,
    parameter int WARPS_PER_BLOCK = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bar_valid,
    input  logic [WARP_ID_W-1:0]       bar_warp_id,
    input  logic [BAR_ID_W-1:0]        bar_barrier_id,
    input  logic [BLOCK_ID_W-1:0]      bar_block_id,
    input  logic [THREAD_MASK_W-1:0]   bar_thread_mask,
    output logic                       bar_error,
    output logic [BAR_ID_W-1:0]        arrive_barrier_id,
    output logic [THREAD_MASK_W-1:0]   arrive_thread_mask,
    output logic [BLOCK_ID_W-1:0]      arrive_block_id,
    output logic [WARP_ID_W-1:0]       arrive_warp_id,
    output logic                       arrive_valid,
    input  logic                       arrive_ready,
    input  logic [BAR_ID_W-1:0]        release_barrier_id,
    input  logic [BLOCK_ID_W-1:0]      release_block_id,
    input  logic [WARPS_PER_BLOCK-1:0] release_warp_mask,
    input  logic                       release_valid,
    output logic                       release_ready,
    output logic [NUM_WARPS-1:0]       warp_stalled,
    output logic [NUM_WARPS-1:0]       warp_resume,
    output logic [31:0]                arrive_count,
    output logic [31:0]                stalled_warp_cycles,
    output logic [15:0]                spurious_release_count
);

    // Arrive output register
    logic                  arrive_valid_q;
    warp_bar_entry_t       arrive_entry_q;
    logic [WARP_ID_W-1:0]  arrive_warp_id_q;

    // Status and statistics registers
    logic                  bar_error_q;
    logic                  release_ready_q;
    logic [NUM_WARPS-1:0]  warp_resume_q;
    logic [31:0]           arrive_count_q;
    logic [31:0]           stalled_cycles_q;
    logic [15:0]           spurious_q;

    // Per-warp views
    warp_bar_entry_t       entry_vec [NUM_WARPS];
    logic [NUM_WARPS-1:0]  bar_accept;
    logic [NUM_WARPS-1:0]  pending_vec;
    logic [NUM_WARPS-1:0]  rel_match;
    logic [NUM_WARPS-1:0]  grant;
    logic                  arb_valid;

    logic                  arrive_hs;
    logic                  release_hs;
    logic                  load;
    warp_bar_entry_t       bar_entry;
    warp_bar_entry_t       picked_entry;
    logic [WARP_ID_W-1:0]  picked_id;
    logic [31:0]           stalled_pop;

    assign arrive_hs  = arrive_valid_q && arrive_ready;
    assign release_hs = release_valid && release_ready_q;
    // The output register takes a new pick when empty or as its current one leaves.
    assign load       = arb_valid && (!arrive_valid_q || arrive_ready);

    assign bar_entry = '{barrier_id:  bar_barrier_id,
                         block_id:    bar_block_id,
                         thread_mask: bar_thread_mask};

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            warp_bar_state_e state_q;
            warp_bar_state_e state_d;
            warp_bar_entry_t entry_q;

            // Out-of-range warp ids never match any gi, so they fall through to bar_error.
            assign bar_accept[gi]  = bar_valid && (bar_warp_id == WARP_ID_W'(gi))
                                     && (state_q == RUNNING);
            assign pending_vec[gi] = (state_q == PENDING);
            assign warp_stalled[gi] = (state_q != RUNNING);
            // Only warps already WAITING at the start of the cycle can be released,
            // so a same-cycle arrive handshake never races a release.
            assign rel_match[gi]   = release_hs && (state_q == WAITING)
                                     && (entry_q.barrier_id == release_barrier_id)
                                     && (entry_q.block_id == release_block_id)
                                     && release_warp_mask[gi];
            assign entry_vec[gi]   = entry_q;

            // The four transitions are mutually exclusive: each needs a different state.
            always_comb begin
                state_d = state_q;
                if (bar_accept[gi]) begin
                    state_d = PENDING;
                end else if (load && grant[gi]) begin
                    state_d = SENDING;
                end else if (arrive_hs && (arrive_warp_id_q == WARP_ID_W'(gi))) begin
                    state_d = WAITING;
                end else if (rel_match[gi]) begin
                    state_d = RUNNING;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= RUNNING;
                    entry_q <= '0;
                end else begin
                    state_q <= state_d;
                    if (bar_accept[gi]) begin
                        entry_q <= bar_entry;
                    end
                end
            end
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_WARPS)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pending_vec),
        .advance (load),
        .grant   (grant),
        .valid   (arb_valid)
    );

    // One-hot grant to payload mux
    always_comb begin
        picked_entry = '0;
        picked_id    = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant[w]) begin
                picked_entry = entry_vec[w];
                picked_id    = WARP_ID_W'(w);
            end
        end
    end

    always_comb begin
        stalled_pop = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            stalled_pop = stalled_pop + 32'(warp_stalled[w]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrive_valid_q   <= 1'b0;
            arrive_entry_q   <= '0;
            arrive_warp_id_q <= '0;
        end else if (load) begin
            arrive_valid_q   <= 1'b1;
            arrive_entry_q   <= picked_entry;
            arrive_warp_id_q <= picked_id;
        end else if (arrive_hs) begin
            arrive_valid_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_error_q      <= 1'b0;
            release_ready_q  <= 1'b0;
            warp_resume_q    <= '0;
            arrive_count_q   <= '0;
            stalled_cycles_q <= '0;
            spurious_q       <= '0;
        end else begin
            bar_error_q      <= bar_valid && (bar_accept == '0);
            release_ready_q  <= 1'b1;
            warp_resume_q    <= rel_match;
            stalled_cycles_q <= stalled_cycles_q + stalled_pop;
            if (arrive_hs) begin
                arrive_count_q <= arrive_count_q + 32'd1;
            end
            if (release_hs && (rel_match == '0) && (spurious_q != 16'hFFFF)) begin
                spurious_q <= spurious_q + 16'd1;
            end
        end
    end

    assign arrive_valid           = arrive_valid_q;
    assign arrive_barrier_id      = arrive_entry_q.barrier_id;
    assign arrive_block_id        = arrive_entry_q.block_id;
    assign arrive_thread_mask     = arrive_entry_q.thread_mask;
    assign arrive_warp_id         = arrive_warp_id_q;
    assign bar_error              = bar_error_q;
    assign release_ready          = release_ready_q;
    assign warp_resume            = warp_resume_q;
    assign arrive_count           = arrive_count_q;
    assign stalled_warp_cycles    = stalled_cycles_q;
    assign spurious_release_count = spurious_q;

endmodule

// File: doc/barrier_arrival_unit.md
# barrier_arrival_unit

Warp-side initiator for barrier synchronization. It sits in the warp scheduler and accepts BAR instructions from issue. It serializes them onto the barrier controller's arrive valid/ready channel, holds each issuing warp stalled, and un-stalls warps when the controller's release message names them.

## Interface
Parameters:
- NUM_WARPS, 32, warps tracked by this unit (≤ WARPS_PER_BLOCK).
- WARPS_PER_BLOCK, 32, width of release_warp_mask.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bar_valid  in  1  issue presents a BAR instruction.
- bar_warp_id  in  6  issuing warp.
- bar_barrier_id  in  16  barrier id.
- bar_block_id  in  10  block id.
- bar_thread_mask  in  32  active threads.
- bar_error  out  1  one-cycle pulse: previous-cycle BAR dropped.
- arrive_barrier_id / arrive_thread_mask / arrive_block_id / arrive_warp_id  out  16/32/10/6  arrive payload.
- arrive_valid  out  1  arrive request.
- arrive_ready  in  1  controller accepts.
- release_barrier_id / release_block_id  in  16/10  release key.
- release_warp_mask  in  WARPS_PER_BLOCK  warps released; bit index = arrive_warp_id.
- release_valid  in  1  release message.
- release_ready  out  1  unit accepts release.
- warp_stalled  out  NUM_WARPS  warp not RUNNING.
- warp_resume  out  NUM_WARPS  one-cycle pulse per released warp.
- arrive_count  out  32  arrivals handshaken, wraps.
- stalled_warp_cycles  out  32  sum of popcount(warp_stalled) per cycle, wraps.
- spurious_release_count  out  16  releases matching no warp, saturates at 0xFFFF.

## Operation
- Per-warp state is RUNNING, PENDING, SENDING or WAITING. Each warp also holds registered barrier_id, block_id and thread_mask.
- bar_ready does not exist; BAR is always sampled.
  - If bar_valid is high, bar_warp_id < NUM_WARPS and the warp is RUNNING, the fields are latched and the warp goes RUNNING→PENDING.
  - Otherwise the request is dropped and bar_error pulses the next cycle.
- Arbitration: a round-robin pick among PENDING warps, with priority starting after the last granted warp.
  - It loads the arrive output register when the register is empty, or in the same cycle its handshake completes.
  - The picked warp goes PENDING→SENDING.
- On the handshake (arrive_valid && arrive_ready), the SENDING warp goes →WAITING and arrive_count increments.
  - arrive_valid drops unless a new pick loads in the same cycle.
  - The payload is stable while arrive_valid is high and arrive_ready is low.
- On the release handshake (release_valid && release_ready), every warp w meeting all of these goes →RUNNING and gets its warp_resume[w] pulse the next cycle:
  - w is WAITING at the start of the cycle;
  - its barrier_id and block_id match the release key;
  - release_warp_mask[w] is 1.
- If no warp matches, spurious_release_count increments (saturating). PENDING and SENDING warps are never released.
- release_ready is 0 in reset and 1 from the first clock after reset.

## Timing
- Reset values:
  - arrive_valid, arrive_* fields, bar_error, warp_resume, warp_stalled, release_ready and all counters are 0.
  - All warps are RUNNING and the RR pointer is 0.
- BAR sampled at edge N → warp_stalled set after N. If the channel is idle, arrive_valid is high after N+1 (latency 2).
- Back-to-back PENDING warps issue with no bubble while arrive_ready stays high.
- Release handshake at edge M → warp_stalled cleared and warp_resume pulsed after M.
- A warp released at edge M can issue a new BAR sampled at edge M+1 at the earliest. A BAR for that warp sampled at edge M itself is dropped with bar_error.
- The arrive handshake and a release in the same cycle for the same warp: the release does not apply, because the warp was not WAITING. The warp stays WAITING and the release counts as spurious if nothing else matched.
- stalled_warp_cycles adds popcount(warp_stalled) each cycle, using the registered value.
- Reset asserted mid-operation: everything returns to its reset values immediately, any in-flight arrive is abandoned, and arrive_valid is 0 asynchronously.

## Structure
- Shared package barrier_types gains:
  - the enum warp_bar_state_e {RUNNING, PENDING, SENDING, WAITING} (2 bits);
  - a struct warp_bar_entry_t {barrier_id, block_id, thread_mask}.
- Sub-module rr_arbiter #(N): combinational pick plus a registered pointer. It takes a request vector and advance, and returns a one-hot grant and a valid.

## Test plan
- Single warp: BAR warp 3, id 0x0005, block 2, mask 0xFFFFFFFF, arrive_ready=1 → arrive_valid high 2 cycles later with those fields; warp_stalled[3]=1; arrive_count=1.
- Backpressure: warps 0, 1 and 2 BAR on consecutive cycles, arrive_ready low for 5 cycles → payload for warp 0 is stable. After ready rises, the order is 0, 1, 2 with no bubbles; arrive_count=3.
- Release: warps 1 and 4 WAITING on (0x0007, 9); release with mask 0x00000012 → warp_resume=0x12 for one cycle and warp_stalled[1] and warp_stalled[4] clear.
- Spurious and partial: release (0x0007, 9) with mask 0x1, warp 0 WAITING on id 0x0008 → no state change, spurious_release_count=1; pinning it at 0xFFFF does not wrap.
- Illegal BAR: BAR warp 2 while WAITING, and BAR warp 40 → bar_error pulses, warp 2's stored fields are unchanged, and no arrive is sent.
- Reset mid-send: arrive_valid high with arrive_ready low; assert rst_n low → arrive_valid=0, warp_stalled=0 and counters=0 immediately; normal flow resumes after deassertion.
